nc_pair_stats: RTL

- Downstream consumer of the two-input logic stage, which produces AND (output1) and XOR-parity (output2) bit streams.
- Accepts one (and, xor) bit pair per beat under a valid/ready handshake and accumulates per-frame statistics.
- Emits one registered summary record per frame under a second valid/ready handshake.
- Sits between the logic stage and the result collector in the obfuscator test designs.

---
 rtl/nc_pair_stats.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/nc_pair_stats.sv
// Per-frame statistics over (AND, XOR) bit pairs. Summary records leave through a valid/ready handshake.
// Optional idle-timeout close is built when NC_PAIR_STATS_TIMEOUT_EN is defined.
module nc_pair_stats #(
  parameter int unsigned CNT_W   = 8,
  parameter int unsigned MAX_LEN = 16,
  parameter int unsigned TIMEOUT = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_and,
  input  logic             in_xor,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] out_len,
  output logic [CNT_W-1:0] out_and_cnt,
  output logic [CNT_W-1:0] out_xor_cnt,
  output logic             out_parity,
  output logic             out_maxed,
  output logic             out_timeout
);

  if (MAX_LEN < 1 || MAX_LEN > (2**CNT_W) - 1 || TIMEOUT < 1) begin : g_bad_param
    $error("nc_pair_stats: MAX_LEN or TIMEOUT out of range");
  end

  typedef enum logic {ACCUM, HOLD} state_t;

  state_t           r_state;
  state_t           w_state_nx;
  logic             r_run;
  logic [CNT_W-1:0] r_len;
  logic [CNT_W-1:0] r_and;
  logic [CNT_W-1:0] r_xor;
  logic             r_par;

  logic             w_accept;
  logic             w_at_max;
  logic             w_close;
  logic             w_tmo;
  logic [CNT_W-1:0] w_len_sum;
  logic [CNT_W-1:0] w_and_sum;
  logic [CNT_W-1:0] w_xor_sum;
  logic             w_par_sum;

  assign w_accept  = in_valid && in_ready;
  assign w_at_max  = (r_len == CNT_W'(MAX_LEN - 1));
  assign w_close   = (w_accept && (in_last || w_at_max)) || w_tmo;
  // A timeout close has no accept, so the sums reduce to the current partial totals.
  assign w_len_sum = r_len + CNT_W'(w_accept);
  assign w_and_sum = r_and + CNT_W'(w_accept && in_and);
  assign w_xor_sum = r_xor + CNT_W'(w_accept && in_xor);
  assign w_par_sum = r_par ^ (w_accept && in_xor);

`ifdef NC_PAIR_STATS_TIMEOUT_EN
  localparam int unsigned IDLE_W = $clog2(TIMEOUT + 1);

  logic [IDLE_W-1:0] r_idle;

  // Fires on the edge where the idle count would reach TIMEOUT; an accept on that edge wins.
  assign w_tmo = (r_state == ACCUM) && (r_len != '0) && !w_accept &&
                 (r_idle == IDLE_W'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_idle <= '0;
    end else if (r_state != ACCUM || w_accept || r_len == '0 || w_tmo) begin
      r_idle <= '0;
    end else begin
      r_idle <= r_idle + 1'b1;
    end
  end
`else
  assign w_tmo = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ACCUM;
      r_run   <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_run   <= 1'b1;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      ACCUM:   if (w_close)   w_state_nx = HOLD;
      HOLD:    if (out_ready) w_state_nx = ACCUM;
      default: w_state_nx = ACCUM;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (r_state)
      ACCUM:   in_ready  = r_run;
      HOLD:    out_valid = 1'b1;
      default: in_ready  = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || w_close) begin
      r_len <= '0;
      r_and <= '0;
      r_xor <= '0;
      r_par <= 1'b0;
    end else if (w_accept) begin
      r_len <= w_len_sum;
      r_and <= w_and_sum;
      r_xor <= w_xor_sum;
      r_par <= w_par_sum;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_len     <= '0;
      out_and_cnt <= '0;
      out_xor_cnt <= '0;
      out_parity  <= 1'b0;
      out_maxed   <= 1'b0;
      out_timeout <= 1'b0;
    end else if (w_close) begin
      out_len     <= w_len_sum;
      out_and_cnt <= w_and_sum;
      out_xor_cnt <= w_xor_sum;
      out_parity  <= w_par_sum;
      out_maxed   <= w_accept && w_at_max && !in_last;
      out_timeout <= w_tmo;
    end
  end

endmodule
